instr_fetch_reg: RTL and testbench
==================================

INSTR_FETCH_REG -- requirements
Module: instr_fetch_reg

Interface
REQ-001 Parameter ADDR_W, default 8, width of program addresses.
REQ-002 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 mem_req  output  1  fetch request to instruction memory.
REQ-006 mem_addr  output  ADDR_W  fetch address, valid while mem_req=1.
REQ-007 mem_rdata  input  16  instruction word returned by memory.
REQ-008 mem_rvalid  input  1  mem_rdata valid this cycle; answers the single outstanding request.
REQ-009 ir  output  16  registered instruction word driven to the opcode decoders.
REQ-010 ir_valid  output  1  ir holds a valid instruction.
REQ-011 ir_ready  input  1  decode/execute consumes ir this cycle.
REQ-012 ir_pc  output  ADDR_W  address ir was fetched from.
REQ-013 redirect  input  1  branch taken; flush and refetch from redirect_pc.
REQ-014 redirect_pc  input  ADDR_W  branch target, sampled when redirect=1.
REQ-015 halt  input  1  level; no new fetch request issued while high.

Function
REQ-016 FSM states: REQ, WAIT, DROP, HOLD; encoding free.
REQ-017 REQ: mem_req=1, mem_addr=pc; next state WAIT unless halt=1 (stay REQ with mem_req=0).
REQ-018 WAIT: mem_req=1, mem_addr stable; on mem_rvalid: ir<=mem_rdata, ir_pc<=pc, ir_valid<=1, pc<=pc+1, go HOLD.
REQ-019 HOLD: ir, ir_pc, ir_valid stable until ir_valid&ir_ready; on handshake ir_valid<=0, go REQ (next request issued the following cycle).
REQ-020 One request outstanding at most; mem_req never asserts while ir_valid=1 (no prefetch).
REQ-021 pc+1 wraps modulo 2^ADDR_W (all-ones -> 0), no flag.
REQ-022 redirect in REQ or HOLD: pc<=redirect_pc, ir_valid<=0 next cycle, go REQ; held ir discarded without handshake.
REQ-023 redirect in WAIT without mem_rvalid: pc<=redirect_pc, go DROP; in WAIT with mem_rvalid same cycle: returned word discarded, pc<=redirect_pc, go REQ.
REQ-024 DROP: mem_req=0; on mem_rvalid discard data, go REQ; a further redirect in DROP updates pc only.
REQ-025 redirect has priority over ir_ready handshake and over halt; halt does not block a redirect pc update.
REQ-026 Minimum fetch latency: request cycle to ir_valid=1 is mem latency+1 cycles; back-to-back throughput one instruction per 3 cycles with 1-cycle memory.
REQ-027 All outputs driven from registers or from state only; no combinational path from mem_rdata to ir.

Reset
REQ-028 rst_n=0 forces immediately: state=REQ, pc=RESET_PC, ir=16'h0000, ir_pc=0, ir_valid=0, mem_req=0.
REQ-029 First mem_req=1 occurs in first rising edge cycle after rst_n deasserts.
REQ-030 Reset mid-WAIT abandons the request; a late mem_rvalid after reset arriving in REQ is ignored.

Configuration
REQ-031 Macro IFETCH_PERF_EN: when defined, adds output fetch_count (16 bits) counting handshakes ir_valid&ir_ready, wrapping at 16'hFFFF, reset 0, plus output flush_count (8 bits) counting redirects, saturating at 8'hFF.
REQ-032 Without IFETCH_PERF_EN neither port nor counters exist; all other behaviour identical.

Verification
REQ-033 Reset release, 1-cycle memory returning 16'h040B at addr 0, ir_ready=1 -> mem_addr=0, ir=16'h040B, ir_valid high one cycle, ir_pc=0, next mem_addr=1.
REQ-034 ir_ready=0 for 5 cycles with ir valid -> ir/ir_pc stable, mem_req=0 throughout; on ir_ready=1 fetch of pc+1 starts next cycle.
REQ-035 redirect to 8'h40 in WAIT, memory answers 3 cycles later with 16'hFFFF -> word dropped, ir_valid stays 0, next mem_addr=8'h40.
REQ-036 ADDR_W=8, pc=8'hFF fetched -> next mem_addr=8'h00.
REQ-037 halt=1 from reset for 4 cycles -> mem_req=0; halt=0 -> mem_addr=RESET_PC; redirect during halt changes first address.
REQ-038 IFETCH_PERF_EN defined, 10 consumed instructions and 2 redirects -> fetch_count=10, flush_count=2; rst_n=0 mid-run -> both 0.

Source files
------------

// File: rtl/instr_fetch_reg.sv
// -----------------------------------------------------------------------------
// instr_fetch_reg
// Single-outstanding instruction fetch unit with a registered instruction
// register (IR) handed to the opcode decoders through a valid/ready pair.
// No prefetch: a new fetch is only issued after the held IR is consumed or
// flushed by a redirect.
//
// Optional feature macro: IFETCH_PERF_EN
//   When defined, adds fetch_count (wrapping count of consumed instructions)
//   and flush_count (saturating count of redirect cycles).
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   mem_req      fetch request to instruction memory (registered)
//   mem_addr     fetch address (the pc register)
//   mem_rdata    instruction word from memory
//   mem_rvalid   mem_rdata valid; answers the outstanding request
//   ir           registered instruction word
//   ir_valid     ir holds a valid instruction
//   ir_ready     consumer takes ir this cycle
//   ir_pc        address ir was fetched from
//   redirect     branch taken: flush and refetch from redirect_pc
//   redirect_pc  branch target
//   halt         level; suppresses new fetch requests
//   fetch_count  (IFETCH_PERF_EN) consumed instructions, wraps
//   flush_count  (IFETCH_PERF_EN) redirects, saturates
// -----------------------------------------------------------------------------
// state  | meaning
// REQ    | issue (mem_req=1) or, when halted/just reset, idle with mem_req=0
// WAIT   | request outstanding, waiting for mem_rvalid
// DROP   | flushed while outstanding; swallow the stale response
// HOLD   | ir valid, waiting for the ir_valid & ir_ready handshake
// -----------------------------------------------------------------------------
module instr_fetch_reg #(
  parameter int          ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [15:0]       ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [7:0]        flush_count
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [15:0]       ir_nxt;
  logic [ADDR_W-1:0] ir_pc_nxt;
  logic              ir_valid_nxt;
  logic              mem_req_nxt;
  logic              handshake;

  // mem_req is a register rather than a state decode so that it is low
  // during reset and for the first cycle after release, and so that halt
  // acts on the request of the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      pc       <= PC_INIT;
      ir       <= 16'h0000;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      mem_req  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      ir       <= ir_nxt;
      ir_pc    <= ir_pc_nxt;
      ir_valid <= ir_valid_nxt;
      mem_req  <= mem_req_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    ir_nxt       = ir;
    ir_pc_nxt    = ir_pc;
    ir_valid_nxt = ir_valid;
    mem_req_nxt  = 1'b0;
    handshake    = 1'b0;
    case (state)
      S_REQ: begin
        if (redirect) begin
          pc_nxt       = redirect_pc;
          ir_valid_nxt = 1'b0;
          mem_req_nxt  = !halt;
        end else if (mem_req) begin
          state_nxt   = S_WAIT;
          mem_req_nxt = 1'b1;
        end else begin
          // idle REQ cycle (reset exit or halt); any stray rvalid is ignored
          mem_req_nxt = !halt;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_nxt = redirect_pc;
          if (mem_rvalid) begin
            state_nxt   = S_REQ;
            mem_req_nxt = !halt;
          end else begin
            state_nxt = S_DROP;
          end
        end else if (mem_rvalid) begin
          ir_nxt       = mem_rdata;
          ir_pc_nxt    = pc;
          ir_valid_nxt = 1'b1;
          pc_nxt       = pc + 1'b1;
          state_nxt    = S_HOLD;
        end else begin
          mem_req_nxt = 1'b1;
        end
      end
      S_DROP: begin
        if (redirect) begin
          pc_nxt = redirect_pc;
        end
        if (mem_rvalid) begin
          state_nxt   = S_REQ;
          mem_req_nxt = !halt;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_nxt       = redirect_pc;
          ir_valid_nxt = 1'b0;
          state_nxt    = S_REQ;
          mem_req_nxt  = !halt;
        end else if (ir_ready) begin
          handshake    = 1'b1;
          ir_valid_nxt = 1'b0;
          state_nxt    = S_REQ;
          mem_req_nxt  = !halt;
        end
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  assign mem_addr = pc;

`ifdef IFETCH_PERF_EN
  // A handshake overridden by a redirect is not a consumed instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= 16'h0000;
      flush_count <= 8'h00;
    end else begin
      if (handshake) begin
        fetch_count <= fetch_count + 16'h0001;
      end
      if (redirect && (flush_count != 8'hFF)) begin
        flush_count <= flush_count + 8'h01;
      end
    end
  end
`else
  logic unused_hs;
  assign unused_hs = handshake;
`endif

endmodule

// File: tb/tb_instr_fetch_reg.sv
module tb_instr_fetch_reg;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic [7:0]  ir_pc;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        halt;
`ifdef IFETCH_PERF_EN
  logic [15:0] fetch_count;
  logic [7:0]  flush_count;
`endif

  int total = 0;
  int bad   = 0;

  instr_fetch_reg #(.ADDR_W(8), .RESET_PC(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .ir_pc       (ir_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt)
`ifdef IFETCH_PERF_EN
    ,
    .fetch_count (fetch_count),
    .flush_count (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory: responds lat negedges after it first sees mem_req,
  // keeps answering even if the DUT is reset or flushed meanwhile
  logic [15:0] mem [256];
  int          lat = 1;
  int          mem_cnt = 0;
  logic        mem_busy = 1'b0;
  logic [7:0]  mem_a = 8'h00;

  always @(negedge clk) begin
    logic answered;
    answered   = 1'b0;
    mem_rvalid = 1'b0;
    if (mem_busy) begin
      mem_cnt = mem_cnt - 1;
      if (mem_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem[mem_a];
        mem_busy   = 1'b0;
        answered   = 1'b1;
      end
    end
    if (!mem_busy && !answered && mem_req) begin
      mem_busy = 1'b1;
      mem_cnt  = lat;
      mem_a    = mem_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in a REQ cycle with mem_req=1; ends holding ir, or (consume=1 and
  // ir_ready=1) in the next REQ cycle.
  task automatic fetch_one(input logic [7:0] a, input logic [15:0] d, input logic consume);
    int n;
    logic [7:0] a_nxt;
    a_nxt = a + 8'd1;
    chk("req", mem_req, 1);
    chk("addr", mem_addr, a);
    n = 0;
    while (!ir_valid && n < 20) begin
      tick();
      n++;
    end
    chk("latency", n, lat + 1);
    chk("ir", ir, d);
    chk("ir_pc", ir_pc, a);
    chk("no_prefetch", mem_req, 0);
    if (consume) begin
      tick();
      chk("hs_valid", ir_valid, 0);
      chk("hs_req", mem_req, 1);
      chk("hs_addr", mem_addr, a_nxt);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'hA5, i[7:0]};
    mem[0] = 16'h040B;
    mem[2] = 16'hFFFF;
    mem_rdata   = 16'h0000;
    mem_rvalid  = 1'b0;
    rst_n       = 1'b0;
    ir_ready    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    halt        = 1'b0;

    // reset values
    #3;
    chk("rst_req", mem_req, 0);
    chk("rst_valid", ir_valid, 0);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_ir_pc", ir_pc, 0);
    chk("rst_addr", mem_addr, 0);
    tick();
    rst_n = 1'b1;

    // first request on the first edge after release, word 040B from addr 0
    tick();
    fetch_one(8'h00, 16'h040B, 1);

    // consumer stalls 5 cycles
    ir_ready = 1'b0;
    fetch_one(8'h01, 16'hA501, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_ir", ir, 16'hA501);
      chk("stall_pc", ir_pc, 8'h01);
      chk("stall_valid", ir_valid, 1);
      chk("stall_req", mem_req, 0);
    end
    ir_ready = 1'b1;
    tick();
    chk("resume_req", mem_req, 1);
    chk("resume_addr", mem_addr, 8'h02);

    // redirect in WAIT, second redirect in DROP, slow memory answers FFFF
    lat = 3;
    tick();
    chk("wait_req", mem_req, 1);
    chk("wait_addr", mem_addr, 8'h02);
    redirect = 1'b1; redirect_pc = 8'h30;
    tick();
    redirect = 1'b0;
    chk("drop_req", mem_req, 0);
    redirect = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect = 1'b0;
    chk("drop_req2", mem_req, 0);
    chk("drop_addr", mem_addr, 8'h40);
    for (int n = 0; n < 10 && !mem_req; n++) begin
      tick();
      chk("drop_valid", ir_valid, 0);
    end
    lat = 1;
    chk("refetch_addr", mem_addr, 8'h40);
    ir_ready = 1'b0;
    fetch_one(8'h40, 16'hA540, 0);

    // redirect in HOLD beats the handshake; then pc wraps FF -> 00
    ir_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 8'hFF;
    tick();
    redirect = 1'b0;
    chk("flush_valid", ir_valid, 0);
    chk("flush_req", mem_req, 1);
    chk("flush_addr", mem_addr, 8'hFF);
    fetch_one(8'hFF, 16'hA5FF, 1);

    // redirect in WAIT in the same cycle as rvalid: word discarded
    tick();
    redirect = 1'b1; redirect_pc = 8'h10;
    tick();
    redirect = 1'b0;
    chk("same_valid", ir_valid, 0);
    chk("same_req", mem_req, 1);
    chk("same_addr", mem_addr, 8'h10);
    fetch_one(8'h10, 16'hA510, 1);

    // reset mid-WAIT with halt high; late rvalid ignored; redirect while halted
    lat = 3;
    tick();
    rst_n = 1'b0;
    halt  = 1'b1;
    #1;
    chk("mrst_req", mem_req, 0);
    chk("mrst_valid", ir_valid, 0);
    chk("mrst_ir", ir, 16'h0000);
    chk("mrst_ir_pc", ir_pc, 0);
    chk("mrst_addr", mem_addr, 0);
    tick();
    rst_n = 1'b1;
    lat = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        redirect = 1'b1; redirect_pc = 8'h20;
      end
      tick();
      redirect = 1'b0;
      chk("halt_req", mem_req, 0);
      chk("halt_valid", ir_valid, 0);
    end
    chk("halt_addr", mem_addr, 8'h20);
    halt = 1'b0;
    tick();
    fetch_one(8'h20, 16'hA520, 1);

    // halt from reset without redirect: first fetch at RESET_PC
    rst_n = 1'b0;
    halt  = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt2_req", mem_req, 0);
    end
    halt = 1'b0;
    tick();
    fetch_one(8'h00, 16'h040B, 1);

`ifdef IFETCH_PERF_EN
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) fetch_one(i[7:0], mem[i], 1);
    ir_ready = 1'b0;
    fetch_one(8'h0A, mem[8'h0A], 0);
    ir_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 8'h50;
    tick();
    redirect = 1'b0;
    ir_ready = 1'b0;
    fetch_one(8'h50, mem[8'h50], 0);
    redirect = 1'b1; redirect_pc = 8'h60;
    tick();
    redirect = 1'b0;
    chk("fetch_count", fetch_count, 10);
    chk("flush_count", flush_count, 2);
    rst_n = 1'b0;
    #1;
    chk("fetch_count_rst", fetch_count, 0);
    chk("flush_count_rst", flush_count, 0);
    tick();
    rst_n = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
